fir_block_collector: RTL
========================

// Module: fir_block_collector
// PURPOSE
//  Receiving end of the FIR output stream. Captures fir_d samples qualified by fir_valid.
//  Packs them into N-sample blocks in a ping-pong (two-bank) buffer.
//  Presents each block to the downstream block processor (FFT stage) over a valid/ready handshake.
//  Tags the block that closes each FRAME-sample frame.
// PARAMETERS
//  DW     16    sample width, two's complement, passed bit-exact
//  N      16    samples per block (power of 2, >=2)
//  FRAME  1024  samples per frame (multiple of N); blk_last marks final block of frame
// PORTS
//  clk        in   1      single clock, rising edge
//  rst        in   1      asynchronous, active-high reset
//  fir_d      in   DW     FIR output sample (signed)
//  fir_valid  in   1      fir_d valid this cycle; no backpressure to FIR
//  blk_data   out  N*DW   block; lane k = blk_data[k*DW +: DW] = k-th sample of block
//  blk_valid  out  1      block available
//  blk_ready  in   1      downstream accepts block when blk_valid && blk_ready
//  blk_last   out  1      qualified by blk_valid: block holds frame sample FRAME-1
//  overflow   out  1      sticky: a valid sample was dropped (both banks full)
// BEHAVIOUR
//  Reset (async, rst=1): blk_valid=0, blk_last=0, overflow=0, blk_data=0.
//    Reset also clears: bank full flags, write bank wb=0, read bank rb=0, wptr=0, frame count fcnt=0.
//    Reset mid-block discards the partial block.
//  Per-bank state: EMPTY -> FILLING (first sample written) -> FULL (N-th sample written)
//    -> EMPTY (block accepted).
//  Write:
//    - A sample is accepted when fir_valid && (!full[wb] || (acc && rb==wb)),
//      where acc = blk_valid && blk_ready.
//    - Accepted sample goes to bank[wb] lane wptr. wptr increments; fcnt increments mod FRAME.
//    - When wptr==N-1: full[wb]<=1, last[wb]<=(fcnt==FRAME-1), wptr<=0, wb toggles.
//  Drop:
//    - fir_valid while full[wb] and the same bank is not released this cycle:
//      the sample is discarded and overflow<=1.
//    - wptr and fcnt do not advance. overflow stays 1 until reset.
//  Read:
//    - blk_valid=full[rb]; blk_data=bank[rb]; blk_last=last[rb].
//    - On acc: full[rb]<=0, rb toggles.
//    - blk_data and blk_last hold stable while blk_valid && !blk_ready.
//  Latency: N-th sample accepted at edge t. If rb points to that bank, blk_valid=1 from edge t.
//    (i.e. visible in the cycle after the sample is presented).
//  Simultaneous write completion and acc in the same cycle: both take effect.
//    Steady state with blk_ready=1 sustains one sample per cycle with no drops.
//  fcnt wraps FRAME-1 -> 0. blk_last is 1 exactly once per FRAME accepted samples.
//  No arithmetic on data: samples are stored and output bit-exact.
// TESTING
//  1) blk_ready=1; feed 1..16 on consecutive cycles
//     -> blk_valid 1 cycle after sample 16; lanes 0..15 = 1..16; blk_last=0.
//  2) blk_ready=0; feed 33 samples 1..33
//     -> both banks full after 32; sample 33 dropped; overflow=1.
//     Then blk_ready=1 -> blocks 1..16 then 17..32; overflow stays 1.
//  3) blk_ready=1; 1025 continuous samples
//     -> 64 blocks; blk_last=1 only on block 64.
//     Sample 1025 is lane 0 of block 65, blk_last=0.
//  4) Both banks full, blk_ready=1 and fir_valid=1 same cycle
//     -> sample accepted into the freed bank; overflow stays 0.
//  5) Feed 7 samples, pulse rst mid-stream
//     -> outputs 0 immediately; the next 16 samples form a clean block with lane 0 = first post-reset sample.
//  6) Feed 16'h8000, 16'h7FFF, 16'hFFFF pattern with gaps in fir_valid
//     -> lanes bit-exact; gaps insert nothing.

Source files
------------

// File: rtl/fir_block_collector.sv
// fir_block_collector: packs FIR samples into N-sample ping-pong blocks for the FFT stage,
// with a valid/ready block handshake, a frame-end tag and a sticky overflow flag.
module fir_block_collector #(
    parameter int DW    = 16,
    parameter int N     = 16,
    parameter int FRAME = 1024
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [DW-1:0]   fir_d,
    input  logic            fir_valid,
    output logic [N*DW-1:0] blk_data,
    output logic            blk_valid,
    input  logic            blk_ready,
    output logic            blk_last,
    output logic            overflow
);
    localparam int AW = $clog2(N);
    localparam int FW = $clog2(FRAME);

    logic [DW-1:0] mem [2][N];
    logic [1:0]    full, last;
    logic          wb, rb, acc, wr;
    logic [AW-1:0] wptr;
    logic [FW-1:0] fcnt;

    assign acc       = blk_valid && blk_ready;
    // a full write bank can still take a sample in the cycle it is being released
    assign wr        = fir_valid && (!full[wb] || (acc && rb == wb));
    assign blk_valid = full[rb];
    assign blk_last  = full[rb] && last[rb];

    for (genvar k = 0; k < N; k++) begin : g_lane
        assign blk_data[k*DW +: DW] = mem[rb][k];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int b = 0; b < 2; b++)
                for (int i = 0; i < N; i++)
                    mem[b][i] <= '0;
            full     <= '0;
            last     <= '0;
            wb       <= 1'b0;
            rb       <= 1'b0;
            wptr     <= '0;
            fcnt     <= '0;
            overflow <= 1'b0;
        end else begin
            if (acc) begin
                full[rb] <= 1'b0;
                rb       <= ~rb;
            end
            if (wr) begin
                mem[wb][wptr] <= fir_d;
                wptr          <= wptr + 1'b1;
                fcnt          <= (fcnt == FW'(FRAME - 1)) ? '0 : fcnt + 1'b1;
                if (wptr == AW'(N - 1)) begin
                    full[wb] <= 1'b1;
                    last[wb] <= (fcnt == FW'(FRAME - 1));
                    wb       <= ~wb;
                end
            end else if (fir_valid) begin
                overflow <= 1'b1;
            end
        end
    end
endmodule
